// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the data_mem_responder slice.
//   mem_state_e : responder FSM states (CLEAR while zeroing the array, READY after)
//   STRB_*      : byte-lane strobe patterns the core is allowed to issue
//   strb_legal  : strobe/offset legality check used when MEM_ALIGN_CHECK_EN is set
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    localparam logic [3:0] STRB_B0  = 4'b0001;
    localparam logic [3:0] STRB_B1  = 4'b0010;
    localparam logic [3:0] STRB_B2  = 4'b0100;
    localparam logic [3:0] STRB_B3  = 4'b1000;
    localparam logic [3:0] STRB_HLO = 4'b0011;
    localparam logic [3:0] STRB_HHI = 4'b1100;
    localparam logic [3:0] STRB_W   = 4'b1111;

    // Byte stores must sit on the lane their offset selects; halfwords must be
    // halfword aligned; words must be word aligned.
    function automatic logic strb_legal(input logic [3:0] strb, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (strb)
            STRB_B0:  ok = (off == 2'd0);
            STRB_B1:  ok = (off == 2'd1);
            STRB_B2:  ok = (off == 2'd2);
            STRB_B3:  ok = (off == 2'd3);
            STRB_HLO: ok = (off == 2'd0);
            STRB_HHI: ok = (off == 2'd2);
            STRB_W:   ok = (off == 2'd0);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_array_2r1w.sv
// -----------------------------------------------------------------------------
// mem_array_2r1w
// DEPTH x 32 storage with two registered read ports and one byte-strobed
// write port. Reads are read-before-write: a read of the word being written
// on the same edge returns the old contents.
// Ports:
//   clk        : clock
//   i_ra_en    : read port A enable (output holds when low)
//   i_ra_addr  : read port A word index
//   o_ra_data  : read port A registered data
//   i_rb_en    : read port B enable
//   i_rb_addr  : read port B word index
//   o_rb_data  : read port B registered data
//   i_we       : per-lane write strobes
//   i_waddr    : write word index
//   i_wdata    : write data (lane aligned)
// -----------------------------------------------------------------------------
module mem_array_2r1w #(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_ra_en,
    input  logic [AW-1:0] i_ra_addr,
    output logic [31:0]   o_ra_data,
    input  logic          i_rb_en,
    input  logic [AW-1:0] i_rb_addr,
    output logic [31:0]   o_rb_data,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata
);

    // One byte-wide array per lane so each lane's write enable is a plain
    // RAM write enable and no array slice is driven from two processes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [0:DEPTH-1];
            logic [7:0] r_ra;
            logic [7:0] r_rb;

            always_ff @(posedge clk) begin
                if (i_we[gi]) begin
                    r_mem[i_waddr] <= i_wdata[8*gi +: 8];
                end
                if (i_ra_en) begin
                    r_ra <= r_mem[i_ra_addr];
                end
                if (i_rb_en) begin
                    r_rb <= r_mem[i_rb_addr];
                end
            end

            assign o_ra_data[8*gi +: 8] = r_ra;
            assign o_rb_data[8*gi +: 8] = r_rb;
        end
    endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Unified instruction/data memory for the core. After reset the whole array is
// zeroed one word per cycle; mem_ready then rises and stays high until the
// next reset. Instruction and data ports read independently with one cycle of
// latency; the data port also writes with byte strobes.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject stores whose strobe
// pattern does not match addr[1:0] (align_err reports them). Without it the
// strobes are applied as given and align_err is constant 0.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   instr_read, instr_addr  : fetch request and byte address
//   instr_out               : fetched word (registered)
//   data_read, data_write   : load request, store lane strobes
//   data_addr, data_in      : load/store byte address, store data
//   data_out                : loaded word (registered, unextended)
//   mem_ready               : clear complete, requests serviced
//   addr_err                : sticky out-of-range access flag
//   align_err               : sticky strobe/offset mismatch flag
// -----------------------------------------------------------------------------
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        addr_err,
    output logic        align_err
);

    localparam int AW = $clog2(DEPTH);

    mem_state_e    r_state;
    mem_state_e    w_state_next;
    logic [AW-1:0] r_clr_idx;
    logic          w_clr_we;
    logic          w_ready;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state. READY is terminal; only rst leaves it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR:   if (r_clr_idx == AW'(DEPTH - 1)) w_state_next = READY;
            READY:   w_state_next = READY;
            default: w_state_next = CLEAR;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_clr_we = 1'b0;
        w_ready  = 1'b0;
        case (r_state)
            CLEAR:   w_clr_we = 1'b1;
            READY:   w_ready  = 1'b1;
            default: w_clr_we = 1'b1;
        endcase
    end

    assign mem_ready = w_ready;

    // Clear index; wraps to 0 naturally on the last cleared word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    // ---------------- request qualification ----------------
    logic          w_instr_oor;
    logic          w_data_oor;
    logic          w_active;
    logic          w_instr_req;
    logic          w_data_rd_req;
    logic          w_data_wr_req;
    logic          w_align_ok;
    logic [3:0]    w_user_we;

    assign w_instr_oor   = |instr_addr[31:AW+2];
    assign w_data_oor    = |data_addr[31:AW+2];
    assign w_active      = w_ready && !rst;
    assign w_instr_req   = w_active && instr_read;
    assign w_data_rd_req = w_active && data_read;
    assign w_data_wr_req = w_active && (data_write != 4'b0000);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_align_ok = strb_legal(data_write, data_addr[1:0]);
`else
    assign w_align_ok = 1'b1;
`endif

    assign w_user_we = (w_data_wr_req && !w_data_oor && w_align_ok) ? data_write : 4'b0000;

    // Write port is shared between the clear sweep and core stores.
    logic [3:0]    w_arr_we;
    logic [AW-1:0] w_arr_waddr;
    logic [31:0]   w_arr_wdata;

    assign w_arr_we    = w_clr_we ? STRB_W : w_user_we;
    assign w_arr_waddr = w_clr_we ? r_clr_idx : data_addr[AW+1:2];
    assign w_arr_wdata = w_clr_we ? 32'h0 : data_in;

    logic [31:0] w_instr_rdata;
    logic [31:0] w_data_rdata;

    mem_array_2r1w #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .i_ra_en   (w_instr_req && !w_instr_oor),
        .i_ra_addr (instr_addr[AW+1:2]),
        .o_ra_data (w_instr_rdata),
        .i_rb_en   (w_data_rd_req && !w_data_oor),
        .i_rb_addr (data_addr[AW+1:2]),
        .o_rb_data (w_data_rdata),
        .i_we      (w_arr_we),
        .i_waddr   (w_arr_waddr),
        .i_wdata   (w_arr_wdata)
    );

    // The RAM read registers carry no reset, so each port keeps a registered
    // "force zero" bit: set by reset and by out-of-range reads, cleared by a
    // serviced in-range read. It updates only when that port is requested,
    // so the output holds together with the RAM register.
    logic r_instr_zero;
    logic r_data_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_zero <= 1'b1;
            r_data_zero  <= 1'b1;
        end else begin
            if (w_instr_req)   r_instr_zero <= w_instr_oor;
            if (w_data_rd_req) r_data_zero  <= w_data_oor;
        end
    end

    assign instr_out = r_instr_zero ? 32'h0 : w_instr_rdata;
    assign data_out  = r_data_zero  ? 32'h0 : w_data_rdata;

    // ---------------- sticky error flags ----------------
    logic r_addr_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else if ((w_instr_req && w_instr_oor) ||
                     ((w_data_rd_req || w_data_wr_req) && w_data_oor)) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err = r_addr_err;

`ifdef MEM_ALIGN_CHECK_EN
    logic r_align_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_align_err <= 1'b0;
        end else if (w_data_wr_req && !w_align_ok) begin
            r_align_err <= 1'b1;
        end
    end

    assign align_err = r_align_err;
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU's instruction and data ports: a unified word-organised RAM with one instruction read port, one data read/write port, byte-strobe writes and registered read data. After reset it runs a sequential clear of the whole array and signals readiness. The core's memory ports connect to it directly, and `mem_ready` gates the core's reset release at top level.

## Interface
- `DEPTH`, 16384: number of 32-bit words; power of two, ≥ 4.
- `AW`, `$clog2(DEPTH)`: derived word-index width; not overridable.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_read` in 1: instruction fetch request.
- `instr_addr` in 32: fetch byte address.
- `instr_out` out 32: fetched word, registered.
- `data_read` in 1: load request.
- `data_write` in 4: byte-lane write strobes; bit k writes `data_in[8k+7:8k]`.
- `data_addr` in 32: load/store byte address.
- `data_in` in 32: store data, already lane-aligned by the core.
- `data_out` out 32: loaded word, raw and unextended, registered.
- `mem_ready` out 1: clear finished, accesses serviced.
- `addr_err` out 1: sticky out-of-range access flag.
- `align_err` out 1: sticky strobe/address mismatch flag; tied 0 unless the macro is defined.

## Operation
- Word index is `addr[AW+1:2]`. `addr[1:0]` is ignored for reads, and a full word is always returned.
- An address is out of range when `addr[31:AW+2] != 0`. On an out-of-range access:
  - A read returns 0.
  - A write is dropped.
  - `addr_err` sets and stays set until `rst`.
- FSM states: CLEAR and READY.
  - `rst` enters CLEAR with `clr_idx = 0`.
  - In CLEAR, word `clr_idx` is written to 0 each cycle and `clr_idx` increments.
  - At `clr_idx == DEPTH-1` the FSM writes that word and moves to READY.
  - READY is terminal until the next `rst`.
  - Asserting `rst` mid-CLEAR restarts the clear at index 0.
- In CLEAR, all requests are ignored: no writes, no flag updates, outputs hold 0.
- Write: when `data_write != 0` in READY and the address is in range, only the lanes with a set strobe update. Unstrobed lanes keep their value.
- Read: in READY, a request with `instr_read` or `data_read` registers the array word into the matching output. With no request, the output holds its previous value.
- The instruction and data ports are independent and can both read in the same cycle.
- Same-cycle write and read to the same word, on either port, is read-before-write: the output gets the old word and the new word is visible from the next request.
- `data_read` and a nonzero `data_write` in the same cycle: both are performed, with old data returned.

## Timing
- Reset values: `instr_out = 0`, `data_out = 0`, `mem_ready = 0`, `addr_err = 0`, `align_err = 0`.
- Clear takes DEPTH cycles after the first cycle with `rst` deasserted. `mem_ready` rises in cycle DEPTH+1 and stays high.
- Read latency is 1 cycle: request and address are sampled at edge N, and data is valid after edge N and held until the next request.
- Write latency is 1 cycle: the write commits at the sampling edge.
- There is no backpressure. The core holds each instruction's address for 3 cycles, so latency 1 meets its timing.
- Flags set on the same edge that samples the offending request.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: each write's strobe pattern is checked against `addr[1:0]`. Legal combinations are:
  - `0001 << addr[1:0]`
  - `0011` with `addr[1:0] = 00`
  - `1100` with `addr[1:0] = 10`
  - `1111` with `addr[1:0] = 00`
- When a check fails:
  - The write is dropped.
  - `align_err` sets (sticky).
- `MEM_ALIGN_CHECK_EN` undefined: strobes are applied as given, with no checking logic, and `align_err` is constant 0.

## Structure
- Package `mem_pkg` holds:
  - The state enum `mem_state_e`, with values CLEAR and READY.
  - Strobe constants `STRB_B0..STRB_B3`, `STRB_HLO`, `STRB_HHI`, `STRB_W`.
  - A function `strb_legal(strb, off)` used by the alignment check.
- Sub-module `mem_array_2r1w` holds the storage:
  - DEPTH×32 array.
  - Two registered read ports.
  - One byte-strobed write port.
  - Read-before-write semantics.
- The top level holds the FSM, clear mux, range/alignment checks and flags.

## Test plan
- Reset, then wait: `mem_ready` = 0 for DEPTH cycles, then 1. A read of any in-range word (e.g. 0x0, `(DEPTH-1)*4`) returns 0x00000000.
- Write `1111`, address 0x100, data 0xDEADBEEF, then write `0010`, address 0x101, data 0x0000AA00, then read 0x100 → `data_out` = 0xDEADAABEF's lanes merged = 0xDEADAAEF.
- Same cycle: write 0x12345678 to 0x40 and `instr_read` at 0x40 → `instr_out` = old value 0. The next fetch returns 0x12345678.
- Read address `DEPTH*4` → `data_out` = 0 and `addr_err` = 1. A following in-range read succeeds and `addr_err` stays 1 until `rst`.
- Reset asserted at clear index DEPTH/2, held 1 cycle → `mem_ready` rises exactly DEPTH+1 cycles after deassertion.
- With `MEM_ALIGN_CHECK_EN` defined: write `0011` at 0x202 → write dropped, `align_err` = 1. Without the macro the same write updates lanes 0–1 of word 0x200.
